// File: rtl/param_acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, FSM state encoding
// and the instruction-width derivation.
package param_acc_cpu_pkg;

    localparam logic [3:0] OP_LOAD = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    // A 4-bit opcode sits above a DATA_W-bit immediate.
    function automatic int calc_instr_w(input int data_w);
        return 4 + data_w;
    endfunction

endpackage

// File: rtl/param_acc_cpu_alu.sv
// Combinational ALU for the accumulator CPU; opcodes outside LOAD..XOR pass
// the accumulator through with carry low.
module acc_alu
    import param_acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero,
    output logic              o_carry
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // Extended-width add/sub so the MSB is the carry (or borrow) out.
    assign w_sum  = {1'b0, i_acc} + {1'b0, i_imm};
    assign w_diff = {1'b0, i_acc} - {1'b0, i_imm};

    always_comb begin
        o_result = i_acc;
        o_carry  = 1'b0;
        case (i_op)
            OP_LOAD: o_result = i_imm;
            OP_ADD:  {o_carry, o_result} = w_sum;
            OP_SUB:  {o_carry, o_result} = w_diff;
            OP_AND:  o_result = i_acc & i_imm;
            OP_OR:   o_result = i_acc | i_imm;
            OP_XOR:  o_result = i_acc ^ i_imm;
            default: o_result = i_acc;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/param_acc_cpu.sv
// Two-cycle-per-instruction accumulator CPU with a writable program memory
// that is loaded while IDLE and survives reset.
module param_acc_cpu
    import param_acc_cpu_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int ADDR_W  = 4,
    localparam int INSTR_W = calc_instr_w(DATA_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    output logic [DATA_W-1:0]  acc_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               busy,
    output logic               halted
);

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_acc;
    logic               r_zero;
    logic               r_carry;
    logic               r_halted;
    logic [INSTR_W-1:0] r_ir;
    logic [INSTR_W-1:0] r_mem [2**ADDR_W];

    logic [3:0]         w_op;
    logic [DATA_W-1:0]  w_imm;
    logic [DATA_W-1:0]  w_alu_result;
    logic               w_alu_zero;
    logic               w_alu_carry;
    logic               w_alu_op;
    logic               w_take_jump;
    logic [ADDR_W-1:0]  w_pc_next;

    assign w_op  = r_ir[INSTR_W-1:DATA_W];
    assign w_imm = r_ir[DATA_W-1:0];

    acc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op     (w_op),
        .i_acc    (r_acc),
        .i_imm    (w_imm),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero),
        .o_carry  (w_alu_carry)
    );

    // Only LOAD..XOR touch acc and flags; everything else leaves them alone.
    assign w_alu_op    = (w_op <= OP_XOR);
    assign w_take_jump = (w_op == OP_JMP) ||
                         ((w_op == OP_JZ) && r_zero) ||
                         ((w_op == OP_JC) && r_carry);
    assign w_pc_next   = w_take_jump ? w_imm[ADDR_W-1:0] : r_pc + ADDR_W'(1);

    // Program memory is deliberately not reset and only writable while IDLE.
    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_acc    <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_halted <= 1'b0;
            r_ir     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pc     <= '0;
                        r_halted <= 1'b0;
                        r_state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_ir    <= r_mem[r_pc];
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_alu_op) begin
                        r_acc   <= w_alu_result;
                        r_zero  <= w_alu_zero;
                        r_carry <= w_alu_carry;
                    end
                    if (w_op == OP_HLT) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_pc    <= w_pc_next;
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign acc_out    = r_acc;
    assign pc_out     = r_pc;
    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;
    assign busy       = (r_state != ST_IDLE);
    assign halted     = r_halted;

endmodule

// File: tb/tb_param_acc_cpu.sv
// Self-checking bench for param_acc_cpu: directed scenarios followed by random
// programs compared instruction-by-instruction against an ISA-level model.
module tb_param_acc_cpu;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int INSTR_W = 12;
    localparam int DEPTH   = 16;

    logic               clk;
    logic               reset;
    logic               prog_we;
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               start;
    logic [DATA_W-1:0]  acc_out;
    logic [ADDR_W-1:0]  pc_out;
    logic               zero_flag;
    logic               carry_flag;
    logic               busy;
    logic               halted;

    int errors = 0;
    int checks = 0;

    logic [INSTR_W-1:0] mMem [DEPTH];
    int mAcc;
    int mPc;
    bit mZero;
    bit mCarry;
    bit mHalted;

    param_acc_cpu #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .acc_out    (acc_out),
        .pc_out     (pc_out),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .busy       (busy),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic applyStimulus(input int addr, input logic [INSTR_W-1:0] data);
        prog_we   = 1'b1;
        prog_addr = addr[ADDR_W-1:0];
        prog_data = data;
        @(negedge clk);
        prog_we   = 1'b0;
        mMem[addr] = data;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic startRun();
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        mPc     = 0;
        mHalted = 1'b0;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        mAcc    = 0;
        mPc     = 0;
        mZero   = 1'b0;
        mCarry  = 1'b0;
        mHalted = 1'b0;
    endtask

    // Instruction-level reference: one call retires one instruction.
    task automatic modelStep();
        logic [INSTR_W-1:0] w;
        int op;
        int imm;
        int s;
        int nextPc;
        w      = mMem[mPc];
        op     = int'(w[11:8]);
        imm    = int'(w[7:0]);
        nextPc = (mPc + 1) % DEPTH;
        case (op)
            0: begin mAcc = imm; mCarry = 1'b0; mZero = (mAcc == 0); end
            1: begin s = mAcc + imm; mCarry = (s > 255); mAcc = s % 256; mZero = (mAcc == 0); end
            2: begin s = mAcc - imm; mCarry = (s < 0); mAcc = (s + 256) % 256; mZero = (mAcc == 0); end
            3: begin mAcc = mAcc & imm; mCarry = 1'b0; mZero = (mAcc == 0); end
            4: begin mAcc = mAcc | imm; mCarry = 1'b0; mZero = (mAcc == 0); end
            5: begin mAcc = mAcc ^ imm; mCarry = 1'b0; mZero = (mAcc == 0); end
            6: nextPc = imm % DEPTH;
            7: if (mZero) nextPc = imm % DEPTH;
            8: if (mCarry) nextPc = imm % DEPTH;
            15: begin mHalted = 1'b1; nextPc = mPc; end
            default: ;
        endcase
        mPc = nextPc;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".acc"}, acc_out, mAcc);
        checkOutput({tag, ".pc"}, pc_out, mPc);
        checkOutput({tag, ".zero"}, zero_flag, mZero);
        checkOutput({tag, ".carry"}, carry_flag, mCarry);
        checkOutput({tag, ".halted"}, halted, mHalted);
        checkOutput({tag, ".busy"}, busy, !mHalted);
    endtask

    task automatic runLockstep(input int maxSteps, input string tag);
        for (int i = 0; i < maxSteps; i++) begin
            modelStep();
            waitCycles(2);
            checkState(tag);
            if (mHalted) break;
        end
        if (!mHalted) applyReset();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        mAcc = 0; mPc = 0; mZero = 1'b0; mCarry = 1'b0; mHalted = 1'b0;
        for (int a = 0; a < DEPTH; a++) mMem[a] = '0;
        waitCycles(2);
        checkOutput("rst.acc", acc_out, 0);
        checkOutput("rst.pc", pc_out, 0);
        checkOutput("rst.zero", zero_flag, 0);
        checkOutput("rst.carry", carry_flag, 0);
        checkOutput("rst.halted", halted, 0);
        checkOutput("rst.busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // LOAD 05, ADD 03, HLT
        applyStimulus(0, 12'h005); applyStimulus(1, 12'h103); applyStimulus(2, 12'hF00);
        startRun();
        waitCycles(5);
        checkOutput("add.busy5", busy, 1);
        checkOutput("add.halted5", halted, 0);
        waitCycles(1);
        checkOutput("add.acc", acc_out, 8'h08);
        checkOutput("add.zero", zero_flag, 0);
        checkOutput("add.carry", carry_flag, 0);
        checkOutput("add.halted", halted, 1);
        checkOutput("add.pc", pc_out, 2);
        checkOutput("add.busy", busy, 0);

        // Overflowing add, then borrowing subtract from the retained zero
        applyStimulus(0, 12'h0FF); applyStimulus(1, 12'h101); applyStimulus(2, 12'hF00);
        startRun(); waitCycles(6);
        checkOutput("ovf.acc", acc_out, 8'h00);
        checkOutput("ovf.carry", carry_flag, 1);
        checkOutput("ovf.zero", zero_flag, 1);
        applyStimulus(0, 12'h201); applyStimulus(1, 12'hF00);
        startRun(); waitCycles(4);
        checkOutput("sub.acc", acc_out, 8'hFF);
        checkOutput("sub.carry", carry_flag, 1);
        checkOutput("sub.zero", zero_flag, 0);
        checkOutput("sub.pc", pc_out, 1);

        // JZ taken skips addr 2; not taken executes it
        applyStimulus(0, 12'h000); applyStimulus(1, 12'h705); applyStimulus(2, 12'h007);
        applyStimulus(3, 12'hF00); applyStimulus(4, 12'hF00); applyStimulus(5, 12'hF00);
        startRun(); waitCycles(6);
        checkOutput("jz.taken.acc", acc_out, 8'h00);
        checkOutput("jz.taken.pc", pc_out, 5);
        applyStimulus(0, 12'h001);
        startRun(); waitCycles(8);
        checkOutput("jz.fall.acc", acc_out, 8'h07);
        checkOutput("jz.fall.pc", pc_out, 3);

        // PC wrap 15 -> 0 -> 1: set zero first, then JZ 0F whose target clears it
        applyStimulus(0, 12'h000); applyStimulus(1, 12'hF00);
        startRun(); waitCycles(4);
        checkOutput("wrap.pre.zero", zero_flag, 1);
        applyStimulus(0, 12'h70F);
        for (int a = 2; a < 15; a++) applyStimulus(a, 12'h900);
        applyStimulus(15, 12'h001);
        startRun(); waitCycles(2);
        checkOutput("wrap.pc15", pc_out, 15);
        waitCycles(2);
        checkOutput("wrap.pc0", pc_out, 0);
        waitCycles(2);
        checkOutput("wrap.pc1", pc_out, 1);
        waitCycles(2);
        checkOutput("wrap.halted", halted, 1);
        checkOutput("wrap.final.pc", pc_out, 1);

        // Reset during EXEC of ADD 03, then re-run the surviving program
        applyStimulus(0, 12'h005); applyStimulus(1, 12'h103); applyStimulus(2, 12'hF00);
        startRun(); waitCycles(3);
        checkOutput("midrst.pre.acc", acc_out, 8'h05);
        reset = 1'b1;
        #1;
        checkOutput("midrst.acc", acc_out, 0);
        checkOutput("midrst.busy", busy, 0);
        checkOutput("midrst.pc", pc_out, 0);
        @(negedge clk);
        reset = 1'b0;
        startRun(); waitCycles(6);
        checkOutput("midrst.rerun.acc", acc_out, 8'h08);
        checkOutput("midrst.rerun.pc", pc_out, 2);
        checkOutput("midrst.rerun.halted", halted, 1);

        // Writes and start while busy must be ignored
        startRun(); waitCycles(1);
        prog_we = 1'b1; prog_addr = '0; prog_data = 12'h077; start = 1'b1;
        waitCycles(2);
        prog_we = 1'b0; start = 1'b0;
        waitCycles(3);
        checkOutput("busywr.acc", acc_out, 8'h08);
        checkOutput("busywr.pc", pc_out, 2);
        checkOutput("busywr.halted", halted, 1);
        startRun(); waitCycles(6);
        checkOutput("busywr.rerun.acc", acc_out, 8'h08);

        // Random programs against the ISA model
        applyReset();
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                applyStimulus(a, {4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))});
            end
            startRun();
            runLockstep(20, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
